pwl_synth_cmd_master: RTL and testbench

Host-side command initiator for the PWL synth pin-level register protocol. It accepts register read/write requests on a valid/ready interface and serialises them into the 16-bit pin command stream: 3-bit command plus 13-bit payload, commands SET_ADDR=4, SET_DATA=5, WRITE=6, READ=7, NOP=0. It captures read data returned on the response pins. It sits in the test/host harness and drives the synth's `ui_in`/`uio_in` pins, so that bus-level tests and on-board controllers never hand-sequence commands.

---
 rtl/pwl_synth_cmd_master_if.sv | 23 ++
 rtl/pwl_synth_cmd_master.sv | 75 +++++++
 tb/tb_pwl_synth_cmd_master.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/pwl_synth_cmd_master_if.sv
// pwl_synth_cmd_master_if: request, pin-level command and response signals of the PWL synth command master
interface pwl_synth_cmd_master_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [5:0]  req_addr;
   logic [12:0] req_wdata;
   logic        addr_inval;
   logic [15:0] pin_out;
   logic [12:0] pin_data;
   logic        pin_ready;
   logic        rsp_valid;
   logic [12:0] rsp_data;
   logic        rsp_err;
   modport master (
      input  req_valid, req_write, req_addr, req_wdata, addr_inval, pin_data, pin_ready,
      output req_ready, pin_out, rsp_valid, rsp_data, rsp_err
   );
   modport slave (
      output req_valid, req_write, req_addr, req_wdata, addr_inval, pin_data, pin_ready,
      input  req_ready, pin_out, rsp_valid, rsp_data, rsp_err
   );
endinterface

// File: rtl/pwl_synth_cmd_master.sv
// pwl_synth_cmd_master: serialises register read/write requests into the PWL synth pin command stream
module pwl_synth_cmd_master #(
   parameter int TIMEOUT    = 255,
   parameter bit CACHE_ADDR = 1'b1
) (
   input logic                    clk,
   input logic                    rst_n,
   pwl_synth_cmd_master_if.master bus
);
   localparam int CW = $clog2(TIMEOUT + 1);
   typedef enum logic [2:0] {IDLE, ADDR, DATA, WR, RD, GAP} state_t;
   state_t        state, state_nxt;
   logic [5:0]    addr, cache_addr;
   logic [12:0]   wdata;
   logic          is_write, cache_valid;
   logic [CW-1:0] cnt;
   logic [15:0]   pin_nxt;
   logic          accept, hit, rd_done, rd_tmo;
   assign accept        = state == IDLE && bus.req_valid;
   assign hit           = CACHE_ADDR && cache_valid && !bus.addr_inval && cache_addr == bus.req_addr;
   assign rd_done       = state == RD && bus.pin_ready;
   assign rd_tmo        = state == RD && !bus.pin_ready && cnt == CW'(TIMEOUT - 1);
   assign bus.req_ready = state == IDLE;
   // transaction sequencing: optional SET_ADDR, then SET_DATA+WRITE or a held READ, then one NOP gap
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = !hit ? ADDR : bus.req_write ? DATA : RD;
         ADDR:    state_nxt = is_write ? DATA : RD;
         DATA:    state_nxt = WR;
         WR:      state_nxt = GAP;
         RD:      if (rd_done || rd_tmo) state_nxt = GAP;
         default: state_nxt = IDLE;
      endcase
   end
   // command word for the state being entered, so pin_out is registered alongside the state
   always_comb begin
      pin_nxt = state_nxt == ADDR ? {3'd4, 7'd0, bus.req_addr} :
                state_nxt == DATA ? {3'd5, state == IDLE ? bus.req_wdata : wdata} :
                state_nxt == WR   ? 16'hC000 :
                state_nxt == RD   ? 16'hE000 : 16'h0000;
   end
   // state, pin register, request latch, read hold counter, response and address cache
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         bus.pin_out   <= '0;
         addr          <= '0;
         wdata         <= '0;
         is_write      <= 1'b0;
         cnt           <= '0;
         bus.rsp_valid <= 1'b0;
         bus.rsp_data  <= '0;
         bus.rsp_err   <= 1'b0;
         cache_addr    <= '0;
         cache_valid   <= 1'b0;
      end else begin
         state         <= state_nxt;
         bus.pin_out   <= pin_nxt;
         cnt           <= state == RD && state_nxt == RD ? cnt + 1'b1 : '0;
         bus.rsp_valid <= rd_done || rd_tmo;
         cache_valid   <= bus.addr_inval || rd_tmo ? 1'b0 : state == ADDR ? 1'b1 : cache_valid;
         if (accept) begin
            addr     <= bus.req_addr;
            wdata    <= bus.req_wdata;
            is_write <= bus.req_write;
         end
         if (rd_done || rd_tmo) begin
            bus.rsp_data <= rd_done ? bus.pin_data : '0;
            bus.rsp_err  <= rd_tmo;
         end
         if (state == ADDR) cache_addr <= addr;
      end
   end
endmodule

// File: tb/tb_pwl_synth_cmd_master.sv
// tb_pwl_synth_cmd_master: transaction-level reference model checking of the PWL synth command master
module tb_pwl_synth_cmd_master;
   localparam int TO = 4;
   logic clk = 1'b0;
   logic rst_n;
   int checks = 0, failures = 0;
   bit inv_en = 1'b0;
   bit m_valid = 1'b0;
   logic [5:0] m_addr = '0;
   pwl_synth_cmd_master_if bus();
   pwl_synth_cmd_master #(.TIMEOUT(TO), .CACHE_ADDR(1'b1)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
   always #5 clk = ~clk;
   initial begin
      #400000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end
   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   // per-cycle side inputs; pin_ready is forced only inside the READ window
   task automatic noise(input bit rd_slot, input bit rdy);
      bus.pin_data   = 13'($urandom);
      bus.pin_ready  = rd_slot ? rdy : 1'($urandom);
      bus.addr_inval = inv_en && ($urandom_range(0, 7) == 0);
      if (bus.addr_inval) m_valid = 1'b0;
   endtask
   task automatic busy_inputs();
      bus.req_valid = 1'($urandom);
      bus.req_write = 1'($urandom);
      bus.req_addr  = 6'($urandom);
      bus.req_wdata = 13'($urandom);
   endtask
   task automatic idle(input int n);
      repeat (n) begin
         bus.req_valid = 1'b0;
         noise(1'b0, 1'b0);
         tick();
         check("idle_ready", 16'(bus.req_ready), 16'd1);
         check("idle_pin", bus.pin_out, 16'h0000);
         check("idle_rsp", 16'(bus.rsp_valid), 16'd0);
      end
   endtask
   // one request: expected command list built from the protocol rules, then walked cycle by cycle
   task automatic run_req(input bit wr, input logic [5:0] a, input logic [12:0] wd, input int d, input logic [12:0] rd);
      logic [15:0] exp_q[$];
      int first_rd;
      bit miss, err;
      check("accept_ready", 16'(bus.req_ready), 16'd1);
      bus.req_valid = 1'b1;
      bus.req_write = wr;
      bus.req_addr  = a;
      bus.req_wdata = wd;
      noise(1'b0, 1'b0);
      miss = !m_valid || m_addr != a;
      if (miss) exp_q.push_back({3'd4, 7'd0, a});
      first_rd = exp_q.size();
      err = !wr && d >= TO;
      if (wr) begin
         exp_q.push_back({3'd5, wd});
         exp_q.push_back(16'hC000);
      end else repeat (err ? TO : d + 1) exp_q.push_back(16'hE000);
      tick();
      if (miss) begin
         m_valid = 1'b1;
         m_addr  = a;
      end
      foreach (exp_q[i]) begin
         check("pin_out", bus.pin_out, exp_q[i]);
         check("busy_ready", 16'(bus.req_ready), 16'd0);
         check("busy_rsp", 16'(bus.rsp_valid), 16'd0);
         busy_inputs();
         noise(!wr && i >= first_rd, (i - first_rd) == d);
         if (!wr && i >= first_rd && (i - first_rd) == d) bus.pin_data = rd;
         tick();
      end
      check("gap_pin", bus.pin_out, 16'h0000);
      check("gap_ready", 16'(bus.req_ready), 16'd0);
      check("rsp_valid", 16'(bus.rsp_valid), 16'(!wr));
      if (!wr) begin
         check("rsp_data", 16'(bus.rsp_data), err ? 16'h0000 : 16'(rd));
         check("rsp_err", 16'(bus.rsp_err), 16'(err));
      end
      if (err) m_valid = 1'b0;
      busy_inputs();
      bus.req_valid = 1'b0;
      noise(1'b0, 1'b0);
      tick();
      check("done_ready", 16'(bus.req_ready), 16'd1);
      check("done_pin", bus.pin_out, 16'h0000);
      check("done_rsp", 16'(bus.rsp_valid), 16'd0);
   endtask
   initial begin
      rst_n          = 1'b0;
      bus.req_valid  = 1'b0;
      bus.req_write  = 1'b0;
      bus.req_addr   = '0;
      bus.req_wdata  = '0;
      bus.addr_inval = 1'b0;
      bus.pin_data   = '0;
      bus.pin_ready  = 1'b0;
      #12;
      check("rst_pin", bus.pin_out, 16'h0000);
      check("rst_ready", 16'(bus.req_ready), 16'd1);
      check("rst_rsp_valid", 16'(bus.rsp_valid), 16'd0);
      check("rst_rsp_data", 16'(bus.rsp_data), 16'd0);
      check("rst_rsp_err", 16'(bus.rsp_err), 16'd0);
      @(negedge clk) rst_n = 1'b1;
      tick();
      run_req(1'b1, 6'h05, 13'h1ABC, 0, 13'h0);
      run_req(1'b1, 6'h05, 13'h0001, 0, 13'h0);
      run_req(1'b0, 6'h05, 13'h0, 3, 13'h0F0F);
      run_req(1'b0, 6'h05, 13'h0, 0, 13'h1234);
      run_req(1'b0, 6'h05, 13'h0, TO, 13'h0);
      run_req(1'b1, 6'h05, 13'h0555, 0, 13'h0);
      bus.addr_inval = 1'b1;
      m_valid = 1'b0;
      tick();
      bus.addr_inval = 1'b0;
      run_req(1'b1, 6'h05, 13'h0AAA, 0, 13'h0);
      bus.addr_inval = 1'b1;
      m_valid = 1'b0;
      tick();
      bus.addr_inval = 1'b0;
      bus.req_valid  = 1'b1;
      bus.req_write  = 1'b1;
      bus.req_addr   = 6'h05;
      bus.req_wdata  = 13'h1ABC;
      tick();
      bus.req_valid = 1'b0;
      check("rst_test_addr", bus.pin_out, 16'h8005);
      tick();
      check("rst_test_data", bus.pin_out, 16'hBABC);
      rst_n = 1'b0;
      #1;
      m_valid = 1'b0;
      check("mid_rst_pin", bus.pin_out, 16'h0000);
      check("mid_rst_ready", 16'(bus.req_ready), 16'd1);
      check("mid_rst_rsp", 16'(bus.rsp_valid), 16'd0);
      @(negedge clk) rst_n = 1'b1;
      tick();
      check("no_write_pin", bus.pin_out, 16'h0000);
      check("no_write_ready", 16'(bus.req_ready), 16'd1);
      run_req(1'b1, 6'h05, 13'h0777, 0, 13'h0);
      inv_en = 1'b1;
      for (int n = 0; n < 250; n++) begin
         run_req(1'($urandom), 6'($urandom_range(0, 3)), 13'($urandom), $urandom_range(0, TO + 1), 13'($urandom));
         idle($urandom_range(0, 2));
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
